// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader FSM state encoding and header/checksum constants.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  localparam int         LOADER_LEN_BYTES = 2;
  localparam logic [7:0] LOADER_CHK_SEED  = 8'h00;

endpackage

// File: rtl/instruction_loader.sv
// Instruction-memory loader: parses a big-endian length header from a
// valid/ready byte stream and writes the payload to addresses 0,1,2,...
// Ports: i_clk, i_reset (sync, active-high), i_start (arm pulse),
//   i_rx_data/i_rx_valid/o_rx_ready (byte stream), o_write_instruction_mem,
//   o_instruction_mem_addr/_data (write port), o_busy, o_done, o_error,
//   o_byte_count (payload bytes written).
// Build option: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic                  o_write_instruction_mem,
  output logic [31:0]           o_instruction_mem_addr,
  output logic [31:0]           o_instruction_mem_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_byte_count
);

  loader_state_t r_state;
  loader_state_t w_next;

  logic [LEN_WIDTH-1:0]  r_len;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_data;

  logic                  w_accept;
  logic                  w_arm;
  logic [LEN_WIDTH-1:0]  w_hdr_len;
  logic                  w_len_zero;
  logic                  w_len_over;
  logic                  w_last;
  loader_state_t         w_end_state;

  assign w_accept = i_rx_valid && o_rx_ready;

  assign w_arm = i_start &&
    (r_state == IDLE || r_state == DONE || r_state == ERR);

  // Header bytes shift in MSB first; this is the full length
  // as it will look once the byte now on the bus is taken.
  assign w_hdr_len  = {r_len[LEN_WIDTH-9:0], i_rx_data};
  assign w_len_zero = (w_hdr_len == '0);
  assign w_len_over =
    (32'(w_hdr_len) > (32'd1 << ADDR_WIDTH));

  // r_cnt is the number of bytes already taken, so the byte on
  // the bus is the last one when r_cnt + 1 reaches the length.
  assign w_last = (32'(r_cnt) + 32'd1) == 32'(r_len);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_chk;
  logic       w_chk_ok;
  assign w_chk_ok    = (i_rx_data == r_chk);
  assign w_end_state = CHK;
`else
  assign w_end_state = DONE;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE, ERR: begin
        if (i_start) w_next = HDR_HI;
      end
      HDR_HI: begin
        if (w_accept) w_next = HDR_LO;
      end
      HDR_LO: begin
        if (w_accept) begin
          if (w_len_zero)      w_next = w_end_state;
          else if (w_len_over) w_next = ERR;
          else                 w_next = DATA;
        end
      end
      DATA: begin
        if (w_accept && w_last) w_next = w_end_state;
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (w_accept) w_next = w_chk_ok ? DONE : ERR;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_len  <= '0;
      r_cnt  <= '0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_chk  <= LOADER_CHK_SEED;
`endif
    end else begin
      r_we <= 1'b0;
      if (w_arm) begin
        r_len <= '0;
        r_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
        r_chk <= LOADER_CHK_SEED;
`endif
      end
      if (w_accept) begin
        if (r_state == HDR_HI || r_state == HDR_LO) begin
          r_len <= w_hdr_len;
        end else if (r_state == DATA) begin
          r_we   <= 1'b1;
          r_addr <= r_cnt[ADDR_WIDTH-1:0];
          r_data <= i_rx_data;
          r_cnt  <= r_cnt + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          r_chk  <= r_chk ^ i_rx_data;
`endif
        end
      end
    end
  end

  assign o_rx_ready = (r_state == HDR_HI) || (r_state == HDR_LO) ||
                      (r_state == DATA)   || (r_state == CHK);

  assign o_busy = o_rx_ready || r_we;
  assign o_done  = (r_state == DONE);
  assign o_error = (r_state == ERR);
  assign o_byte_count = r_cnt;

  assign o_write_instruction_mem = r_we;
  assign o_instruction_mem_addr  =
    {{(32-ADDR_WIDTH){1'b0}}, r_addr};
  assign o_instruction_mem_data  = {24'h0, r_data};

endmodule
